// File: rtl/gfx_span_rasterizer.sv
// Span rasterizer: walks a clipped rectangle row by row, emitting
// beats of `lanes` pixels with matching texture coordinates.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake (ready only in IDLE)
//   dest_*_i                     signed rectangle, x1/y1 exclusive
//   clipping_enable_i, clip_*_i  unsigned clip window, x1/y1 exclusive
//   src_x0_i, src_y0_i           texture origin
//   abort_i                      cancel active command
//   pix_valid_o / pix_ready_i    beat handshake
//   x_o, y_o, u_o, v_o, mask_o   lane-0 coordinates and lane-valid bits
//   done_o                       one-cycle end-of-command pulse
module gfx_span_rasterizer #(
    parameter int point_width = 16,
    parameter int lanes       = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [point_width-1:0] dest_x0_i,
    input  logic [point_width-1:0] dest_y0_i,
    input  logic [point_width-1:0] dest_x1_i,
    input  logic [point_width-1:0] dest_y1_i,
    input  logic                   clipping_enable_i,
    input  logic [point_width-1:0] clip_x0_i,
    input  logic [point_width-1:0] clip_y0_i,
    input  logic [point_width-1:0] clip_x1_i,
    input  logic [point_width-1:0] clip_y1_i,
    input  logic [point_width-1:0] src_x0_i,
    input  logic [point_width-1:0] src_y0_i,
    input  logic                   abort_i,
    output logic                   pix_valid_o,
    input  logic                   pix_ready_i,
    output logic [point_width-1:0] x_o,
    output logic [point_width-1:0] y_o,
    output logic [point_width-1:0] u_o,
    output logic [point_width-1:0] v_o,
    output logic [lanes-1:0]       mask_o,
    output logic                   done_o
);

    localparam int W  = point_width;
    // Two guard bits: one for signed/unsigned mixing, one so that
    // x + lanes and x1 - 1 can never wrap.
    localparam int CW = point_width + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic signed [CW-1:0] ONE   = CW'(1);
    localparam logic signed [CW-1:0] ZERO  = '0;
    localparam logic signed [CW-1:0] LSTEP = CW'(lanes);

    function automatic logic signed [CW-1:0] smax(
        input logic signed [CW-1:0] a,
        input logic signed [CW-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [CW-1:0] smin(
        input logic signed [CW-1:0] a,
        input logic signed [CW-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    logic [1:0] state_q, state_d;
    logic       init_q;

    logic [W-1:0] dx0_q, dx0_d, dy0_q, dy0_d;
    logic [W-1:0] dx1_q, dx1_d, dy1_q, dy1_d;
    logic         clip_en_q, clip_en_d;
    logic [W-1:0] kx0_q, kx0_d, ky0_q, ky0_d;
    logic [W-1:0] kx1_q, kx1_d, ky1_q, ky1_d;
    logic [W-1:0] sx_q, sx_d, sy_q, sy_d;

    logic signed [CW-1:0] cx0_q, cx0_d, cx1_q, cx1_d, cy1_q, cy1_d;
    logic signed [CW-1:0] x_q, x_d, y_q, y_d;
    logic [W-1:0]         u_q, u_d, v_q, v_d, urow_q, urow_d;

    // Setup-stage bound computation from the registered command.
    logic signed [CW-1:0] ex0, ey0, ex1, ey1;
    logic signed [CW-1:0] ekx0, eky0, ekx1, eky1;
    logic signed [CW-1:0] bx0, by0, bx1, by1;
    logic [W-1:0]         u0, v0;
    logic                 empty;

    assign ex0  = {{2{dx0_q[W-1]}}, dx0_q};
    assign ey0  = {{2{dy0_q[W-1]}}, dy0_q};
    assign ex1  = {{2{dx1_q[W-1]}}, dx1_q};
    assign ey1  = {{2{dy1_q[W-1]}}, dy1_q};
    assign ekx0 = {2'b00, kx0_q};
    assign eky0 = {2'b00, ky0_q};
    assign ekx1 = {2'b00, kx1_q};
    assign eky1 = {2'b00, ky1_q};

    assign bx0 = clip_en_q ? smax(ex0, ekx0) : smax(ex0, ZERO);
    assign by0 = clip_en_q ? smax(ey0, eky0) : smax(ey0, ZERO);
    assign bx1 = (clip_en_q ? smin(ex1, ekx1) : ex1) - ONE;
    assign by1 = (clip_en_q ? smin(ey1, eky1) : ey1) - ONE;

    assign u0    = sx_q + W'(bx0 - ex0);
    assign v0    = sy_q + W'(by0 - ey0);
    assign empty = (bx0 > bx1) || (by0 > by1);

    // Emit-stage stepping.
    logic signed [CW-1:0] x_step;
    logic                 row_end, last_row;

    assign x_step   = x_q + LSTEP;
    assign row_end  = x_step > cx1_q;
    assign last_row = y_q >= cy1_q;

    always_comb begin
        state_d   = state_q;
        dx0_d     = dx0_q;
        dy0_d     = dy0_q;
        dx1_d     = dx1_q;
        dy1_d     = dy1_q;
        clip_en_d = clip_en_q;
        kx0_d     = kx0_q;
        ky0_d     = ky0_q;
        kx1_d     = kx1_q;
        ky1_d     = ky1_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        cx0_d     = cx0_q;
        cx1_d     = cx1_q;
        cy1_d     = cy1_q;
        x_d       = x_q;
        y_d       = y_q;
        u_d       = u_q;
        v_d       = v_q;
        urow_d    = urow_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    dx0_d     = dest_x0_i;
                    dy0_d     = dest_y0_i;
                    dx1_d     = dest_x1_i;
                    dy1_d     = dest_y1_i;
                    clip_en_d = clipping_enable_i;
                    kx0_d     = clip_x0_i;
                    ky0_d     = clip_y0_i;
                    kx1_d     = clip_x1_i;
                    ky1_d     = clip_y1_i;
                    sx_d      = src_x0_i;
                    sy_d      = src_y0_i;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort_i || empty) begin
                    state_d = S_DONE;
                end else begin
                    cx0_d   = bx0;
                    cx1_d   = bx1;
                    cy1_d   = by1;
                    x_d     = bx0;
                    y_d     = by0;
                    u_d     = u0;
                    urow_d  = u0;
                    v_d     = v0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (abort_i) begin
                    state_d = S_DONE;
                end else if (pix_ready_i) begin
                    if (!row_end) begin
                        x_d = x_step;
                        u_d = u_q + W'(lanes);
                    end else if (!last_row) begin
                        x_d = cx0_q;
                        u_d = urow_q;
                        y_d = y_q + ONE;
                        v_d = v_q + W'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            init_q    <= 1'b0;
            dx0_q     <= '0;
            dy0_q     <= '0;
            dx1_q     <= '0;
            dy1_q     <= '0;
            clip_en_q <= 1'b0;
            kx0_q     <= '0;
            ky0_q     <= '0;
            kx1_q     <= '0;
            ky1_q     <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            cx0_q     <= '0;
            cx1_q     <= '0;
            cy1_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            u_q       <= '0;
            v_q       <= '0;
            urow_q    <= '0;
        end else begin
            state_q   <= state_d;
            init_q    <= 1'b1;
            dx0_q     <= dx0_d;
            dy0_q     <= dy0_d;
            dx1_q     <= dx1_d;
            dy1_q     <= dy1_d;
            clip_en_q <= clip_en_d;
            kx0_q     <= kx0_d;
            ky0_q     <= ky0_d;
            kx1_q     <= kx1_d;
            ky1_q     <= ky1_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            cx0_q     <= cx0_d;
            cx1_q     <= cx1_d;
            cy1_q     <= cy1_d;
            x_q       <= x_d;
            y_q       <= y_d;
            u_q       <= u_d;
            v_q       <= v_d;
            urow_q    <= urow_d;
        end
    end

    // Lane k is live when its pixel still lies inside the clipped row.
    always_comb begin
        mask_o = '0;
        if (state_q == S_EMIT) begin
            for (int k = 0; k < lanes; k++) begin
                mask_o[k] = (x_q + CW'(k)) <= cx1_q;
            end
        end
    end

    // init_q keeps ready low until the first clock after reset release.
    assign cmd_ready_o = (state_q == S_IDLE) && init_q;
    assign pix_valid_o = (state_q == S_EMIT);
    assign done_o      = (state_q == S_DONE);
    assign x_o         = x_q[W-1:0];
    assign y_o         = y_q[W-1:0];
    assign u_o         = u_q;
    assign v_o         = v_q;

endmodule

// File: tb/tb_gfx_span_rasterizer.sv
// Testbench for gfx_span_rasterizer: directed and randomized commands
// checked beat by beat against a queue-based reference model.
module tb_gfx_span_rasterizer;

    localparam int W = 16;
    localparam int L = 4;

    logic         clk;
    logic         rst_i;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [W-1:0] dest_x0_i, dest_y0_i, dest_x1_i, dest_y1_i;
    logic         clipping_enable_i;
    logic [W-1:0] clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i;
    logic [W-1:0] src_x0_i, src_y0_i;
    logic         abort_i;
    logic         pix_valid_o;
    logic         pix_ready_i;
    logic [W-1:0] x_o, y_o, u_o, v_o;
    logic [L-1:0] mask_o;
    logic         done_o;

    gfx_span_rasterizer #(.point_width(W), .lanes(L)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_ready_o       (cmd_ready_o),
        .dest_x0_i         (dest_x0_i),
        .dest_y0_i         (dest_y0_i),
        .dest_x1_i         (dest_x1_i),
        .dest_y1_i         (dest_y1_i),
        .clipping_enable_i (clipping_enable_i),
        .clip_x0_i         (clip_x0_i),
        .clip_y0_i         (clip_y0_i),
        .clip_x1_i         (clip_x1_i),
        .clip_y1_i         (clip_y1_i),
        .src_x0_i          (src_x0_i),
        .src_y0_i          (src_y0_i),
        .abort_i           (abort_i),
        .pix_valid_o       (pix_valid_o),
        .pix_ready_i       (pix_ready_i),
        .x_o               (x_o),
        .y_o               (y_o),
        .u_o               (u_o),
        .v_o               (v_o),
        .mask_o            (mask_o),
        .done_o            (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] u;
        logic [W-1:0] v;
        logic [L-1:0] m;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // Reference: enumerate every beat of the clipped rectangle in order.
    function automatic void build(int x0, int y0, int x1, int y1, bit en,
                                  int k0, int k1, int k2, int k3,
                                  int sx, int sy);
        int    bx0, bx1, by0, by1;
        beat_t b;
        if (en) begin
            bx0 = imax(x0, k0);
            by0 = imax(y0, k1);
            bx1 = imin(x1, k2) - 1;
            by1 = imin(y1, k3) - 1;
        end else begin
            bx0 = imax(x0, 0);
            by0 = imax(y0, 0);
            bx1 = x1 - 1;
            by1 = y1 - 1;
        end
        for (int y = by0; y <= by1; y++) begin
            for (int x = bx0; x <= bx1; x += L) begin
                b.x = W'(x);
                b.y = W'(y);
                b.u = W'(sx + (x - x0));
                b.v = W'(sy + (y - y0));
                b.m = '0;
                for (int k = 0; k < L; k++) begin
                    if (x + k <= bx1) b.m[k] = 1'b1;
                end
                exp_q.push_back(b);
            end
        end
    endfunction

    // Every cycle a beat is offered it must match the queue head.
    always @(negedge clk) begin
        if (!rst_i && pix_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(pix_valid_o), 32'd0);
            end else begin
                chk("beat_x", 32'(x_o), 32'(exp_q[0].x));
                chk("beat_y", 32'(y_o), 32'(exp_q[0].y));
                chk("beat_u", 32'(u_o), 32'(exp_q[0].u));
                chk("beat_v", 32'(v_o), 32'(exp_q[0].v));
                chk("beat_mask", 32'(mask_o), 32'(exp_q[0].m));
                if (pix_ready_i && !abort_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive_cmd(int x0, int y0, int x1, int y1, bit en,
                             int k0, int k1, int k2, int k3,
                             int sx, int sy);
        dest_x0_i         = W'(x0);
        dest_y0_i         = W'(y0);
        dest_x1_i         = W'(x1);
        dest_y1_i         = W'(y1);
        clipping_enable_i = en;
        clip_x0_i         = W'(k0);
        clip_y0_i         = W'(k1);
        clip_x1_i         = W'(k2);
        clip_y1_i         = W'(k3);
        src_x0_i          = W'(sx);
        src_y0_i          = W'(sy);
        cmd_valid_i       = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid_i       = 1'b0;
        // Scramble inputs: the block must work from its registered copy.
        dest_x0_i         = W'($urandom);
        dest_x1_i         = W'($urandom);
        clip_x1_i         = W'($urandom);
        src_x0_i          = W'($urandom);
        clipping_enable_i = 1'($urandom);
    endtask

    // mode: 0 ready high, 1 random, 2 stall cycles 3..5, 3 ready low.
    task automatic run_cmd(int x0, int y0, int x1, int y1, bit en,
                           int k0, int k1, int k2, int k3,
                           int sx, int sy, int mode, int abort_at,
                           int exp_done);
        int n, c, ab_c, first;
        bit aborted, got_done;
        exp_q.delete();
        build(x0, y0, x1, y1, en, k0, k1, k2, k3, sx, sy);
        n = exp_q.size();
        chk("ready_before_cmd", 32'(cmd_ready_o), 32'd1);
        drive_cmd(x0, y0, x1, y1, en, k0, k1, k2, k3, sx, sy);
        c        = 1;
        ab_c     = -10;
        first    = -1;
        aborted  = 1'b0;
        got_done = 1'b0;
        while (c < 3000 && !got_done) begin
            case (mode)
                0:       pix_ready_i = 1'b1;
                1:       pix_ready_i = ($urandom_range(0, 3) != 0);
                2:       pix_ready_i = !(c >= 3 && c <= 5);
                default: pix_ready_i = 1'b0;
            endcase
            abort_i = (c == abort_at);
            @(negedge clk);
            if (aborted && c == ab_c + 1) begin
                chk("abort_valid_low", 32'(pix_valid_o), 32'd0);
                chk("abort_done", 32'(done_o), 32'd1);
            end
            if (pix_valid_o && first < 0) first = c;
            if (abort_i && !done_o) begin
                aborted = 1'b1;
                ab_c    = c;
            end
            if (done_o) begin
                got_done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (aborted) exp_q.delete();
                c++;
            end
        end
        abort_i     = 1'b0;
        pix_ready_i = 1'b0;
        chk("done_seen", 32'(got_done), 32'd1);
        if (!aborted) chk("beats_left", 32'(exp_q.size()), 32'd0);
        if (mode == 0 && !aborted) chk("done_cycle_model", 32'(c), 32'(2 + n));
        if (mode == 0 && !aborted && n > 0) chk("first_latency", 32'(first), 32'd2);
        if (exp_done >= 0) chk("done_cycle", 32'(c), 32'(exp_done));
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done_o), 32'd0);
        chk("ready_after_done", 32'(cmd_ready_o), 32'd1);
        chk("valid_after_done", 32'(pix_valid_o), 32'd0);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_ready"}, 32'(cmd_ready_o), 32'd0);
        chk({tag, "_valid"}, 32'(pix_valid_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_mask"}, 32'(mask_o), 32'd0);
        chk({tag, "_xyuv"}, {x_o, y_o} | {u_o, v_o}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int x0, y0, x1, y1, k0, k1, k2, k3, ab;
        bit en;
        rst_i             = 1'b1;
        cmd_valid_i       = 1'b0;
        abort_i           = 1'b0;
        pix_ready_i       = 1'b0;
        clipping_enable_i = 1'b0;
        {dest_x0_i, dest_y0_i, dest_x1_i, dest_y1_i} = '0;
        {clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i} = '0;
        {src_x0_i, src_y0_i} = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_release", 32'(cmd_ready_o), 32'd1);

        // abort in IDLE does nothing
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        chk("idle_abort_done", 32'(done_o), 32'd0);
        chk("idle_abort_ready", 32'(cmd_ready_o), 32'd1);

        // pin the model with hand-computed beats
        exp_q.delete();
        build(2, 1, 9, 3, 0, 0, 0, 0, 0, 0, 0);
        chk("pin_a_count", 32'(exp_q.size()), 32'd4);
        chk("pin_a_b0", {exp_q[0].x, 12'd0, exp_q[0].m}, {16'd2, 12'd0, 4'hf});
        chk("pin_a_b1", {exp_q[1].x, 12'd0, exp_q[1].m}, {16'd6, 12'd0, 4'h7});
        chk("pin_a_b3", {exp_q[3].x, exp_q[3].y}, {16'd6, 16'd2});
        exp_q.delete();
        build(0, 0, 8, 1, 1, 4, 0, 6, 10, 10, 20);
        chk("pin_b_count", 32'(exp_q.size()), 32'd1);
        chk("pin_b_xy", {exp_q[0].x, exp_q[0].y}, {16'd4, 16'd0});
        chk("pin_b_uv", {exp_q[0].u, exp_q[0].v}, {16'd14, 16'd20});
        chk("pin_b_mask", 32'(exp_q[0].m), 32'h3);

        // directed commands
        run_cmd(2, 1, 9, 3, 0, 0, 0, 0, 0, 0, 0, 0, -1, 6);
        run_cmd(0, 0, 8, 1, 1, 4, 0, 6, 10, 10, 20, 0, -1, 3);
        run_cmd(5, 5, 5, 9, 0, 0, 0, 0, 0, 7, 7, 0, -1, 2);
        run_cmd(2, 1, 9, 3, 0, 0, 0, 0, 0, 0, 0, 2, -1, 9);
        run_cmd(2, 1, 9, 3, 0, 0, 0, 0, 0, 0, 0, 3, 3, 4);
        run_cmd(-5, -3, 6, 2, 0, 0, 0, 0, 0, 100, 200, 0, -1, -1);
        run_cmd(32760, 0, 32767, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1, 4);
        run_cmd(3, 3, 20, 9, 1, 0, 0, 65535, 65535, 65530, 1, 0, 1, 2);

        // reset during EMIT
        exp_q.delete();
        build(2, 1, 9, 3, 0, 0, 0, 0, 0, 0, 0);
        pix_ready_i = 1'b0;
        drive_cmd(2, 1, 9, 3, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("pre_reset_valid", 32'(pix_valid_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("reset_no_done", 32'(done_o), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_reset_no_done", 32'(done_o), 32'd0);
        @(posedge clk);
        #1;
        run_cmd(0, 0, 8, 1, 1, 4, 0, 6, 10, 10, 20, 0, -1, 3);

        // randomized commands
        for (int i = 0; i < 40; i++) begin
            x0 = int'($urandom_range(0, 40)) - 10;
            x1 = x0 + int'($urandom_range(0, 24)) - 3;
            y0 = int'($urandom_range(0, 12)) - 4;
            y1 = y0 + int'($urandom_range(0, 7)) - 1;
            en = 1'($urandom_range(0, 1));
            k0 = int'($urandom_range(0, 30));
            k2 = k0 + int'($urandom_range(0, 20));
            k1 = int'($urandom_range(0, 8));
            k3 = k1 + int'($urandom_range(0, 8));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : -1;
            run_cmd(x0, y0, x1, y1, en, k0, k1, k2, k3,
                    int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 1)), ab, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
